start_sequencer: RTL and testbench

- Upstream launch stage for the multicore matrix-multiply datapath. Produces the level `start` consumed by clock_corrector_new.
- Takes a raw, asynchronous, bouncy push-button (or host strobe) and synchronises and debounces it.
- Holds `start` high for exactly one job, then drops it on core `done` or on a watchdog timeout.
- Requires a full button release before another job can be launched, so one press gives exactly one run.

---
 rtl/start_sequencer.sv | 118 +++++++++++
 tb/tb_start_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/start_sequencer.sv
// start_sequencer: synchronised, debounced one-shot launch level with
// done/watchdog termination, release lockout and saturating run counter.
module start_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int RUN_CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 btn_in,
   input  logic                 done_in,
   output logic                 start,
   output logic                 busy,
   output logic                 timeout,
   output logic [RUN_CNT_W-1:0] run_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int TM_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_RUN,
      S_RELEASE
   } state_e;

   state_e               state_q, state_d;
   logic                 s1_q, btn_s_q;
   logic [DB_W-1:0]      db_q, db_d;
   logic [TM_W-1:0]      tm_q, tm_d;
   logic                 timeout_q, timeout_d;
   logic [RUN_CNT_W-1:0] run_q, run_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         s1_q      <= 1'b0;
         btn_s_q   <= 1'b0;
         db_q      <= '0;
         tm_q      <= '0;
         timeout_q <= 1'b0;
         run_q     <= '0;
      end else begin
         state_q   <= state_d;
         s1_q      <= btn_in;
         btn_s_q   <= s1_q;
         db_q      <= db_d;
         tm_q      <= tm_d;
         timeout_q <= timeout_d;
         run_q     <= run_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      tm_d      = tm_q;
      timeout_d = timeout_q;
      run_d     = run_q;
      unique case (state_q)
         S_IDLE: begin
            if (btn_s_q) begin
               state_d = S_DEBOUNCE;
               db_d    = '0;
            end
         end
         S_DEBOUNCE: begin
            if (!btn_s_q) begin
               state_d = S_IDLE;
            end else if (db_q == DB_LAST) begin
               state_d   = S_RUN;
               tm_d      = '0;
               timeout_d = 1'b0;
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end
         S_RUN: begin
            // done has priority over a watchdog expiry in the same cycle
            if (done_in) begin
               state_d = S_RELEASE;
               db_d    = '0;
               if (run_q != '1) begin
                  run_d = run_q + RUN_CNT_W'(1);
               end
            end else if (WD_EN && tm_q == TM_LAST) begin
               state_d   = S_RELEASE;
               db_d      = '0;
               timeout_d = 1'b1;
            end else if (tm_q != '1) begin
               tm_d = tm_q + TM_W'(1);
            end
         end
         S_RELEASE: begin
            if (btn_s_q) begin
               db_d = '0;
            end else if (db_q == DB_LAST) begin
               state_d = S_IDLE;
            end else begin
               db_d = db_q + DB_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign start     = (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign timeout   = timeout_q;
   assign run_count = run_q;

endmodule

// File: tb/tb_start_sequencer.sv
// Randomised scoreboard bench for start_sequencer: stimulus predicts each
// launch window; a monitor checks every start pulse against the queue.
module tb_start_sequencer;

   localparam int DB = 4;
   localparam int TO = 20;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         btn_in = 1'b0;
   logic         done_in = 1'b0;
   logic         start, busy, timeout;
   logic [W-1:0] run_count;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      int r;
      int len;
      int rc;
      bit to;
   } job_t;

   job_t q[$];
   int   exp_rc = 0;
   bit   exp_to = 1'b0;
   int   rise = -1;
   logic prev_start = 1'b0;

   start_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TO),
      .RUN_CNT_W      (W)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_in   (btn_in),
      .done_in  (done_in),
      .start    (start),
      .busy     (busy),
      .timeout  (timeout),
      .run_count(run_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every start pulse must match the next predicted job
   always @(negedge clk) begin
      if (start === 1'b1 && prev_start === 1'b0) begin
         rise = cyc;
         chk("launch_expected", int'(q.size() != 0), 1);
      end
      if (start === 1'b0 && prev_start === 1'b1) begin
         chk("end_expected", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            job_t j;
            j = q.pop_front();
            chk("rise_edge", rise, j.r);
            chk("run_len", cyc - rise, j.len);
            chk("run_count_end", int'(run_count), j.rc);
            chk("timeout_end", int'(timeout), int'(j.to));
         end
      end
      prev_start = start;
   end

   task automatic idle_checks(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_start"}, int'(start), 0);
      chk({tag, "_run_count"}, int'(run_count), exp_rc);
      chk({tag, "_timeout"}, int'(timeout), int'(exp_to));
   endtask

   // nb bounces, then a solid press; done on RUN cycle d (0 or >TO: none)
   task automatic job(input int nb, input int d, input int hold);
      int   e, r, len;
      bit   dn;
      job_t j;
      for (int b = 0; b < nb; b++) begin
         repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            btn_in = 1'b1;
         end
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            btn_in = 1'b0;
         end
      end
      @(negedge clk);
      e   = cyc + 1;
      r   = e + DB + 2;
      dn  = (d >= 1 && d <= TO);
      len = dn ? d : TO;
      if (dn) begin
         exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
         exp_to = 1'b0;
      end else begin
         exp_to = 1'b1;
      end
      j.r   = r;
      j.len = len;
      j.rc  = exp_rc;
      j.to  = exp_to;
      q.push_back(j);
      for (int k = e; k <= r + len; k++) begin
         btn_in  = (k < r) ? 1'b1 : 1'($urandom_range(0, 1));
         done_in = (k > r) ? (dn && k == r + d) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (nb == 0 && k == e + 1) chk("busy_pre", int'(busy), 0);
         if (nb == 0 && k == e + 2) chk("busy_debounce", int'(busy), 1);
         if (k > r) chk("busy_run", int'(busy), 1);
      end
      repeat (hold) begin
         btn_in  = 1'b1;
         done_in = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("busy_hold", int'(busy), 1);
      end
      btn_in = 1'b0;
      repeat (DB + 6) begin
         done_in = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      done_in = 1'b0;
      idle_checks("idle");
   endtask

   task automatic job_reset(input int m);
      int   e, r;
      job_t j;
      @(negedge clk);
      e = cyc + 1;
      r = e + DB + 2;
      exp_rc = 0;
      exp_to = 1'b0;
      j.r   = r;
      j.len = m;
      j.rc  = 0;
      j.to  = 1'b0;
      q.push_back(j);
      for (int k = e; k <= r + m; k++) begin
         btn_in  = 1'b1;
         done_in = 1'b0;
         reset_n = (k == r + m) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      chk("rst_start", int'(start), 0);
      chk("rst_run_count", int'(run_count), 0);
      reset_n = 1'b1;
      btn_in  = 1'b0;
      repeat (DB + 6) @(negedge clk);
      idle_checks("post_rst");
   endtask

   task automatic bounce();
      int pat [5] = '{1, 1, 0, 1, 1};
      int seen = 0;
      foreach (pat[i]) begin
         @(negedge clk);
         btn_in = 1'(pat[i]);
         if (busy === 1'b1) seen = 1;
      end
      @(negedge clk);
      btn_in = 1'b0;
      repeat (DB + 6) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1;
      end
      chk("bounce_busy_seen", seen, 1);
      idle_checks("bounce");
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_start", int'(start), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_timeout", int'(timeout), 0);
      chk("reset_run_count", int'(run_count), 0);
      reset_n = 1'b1;

      job(0, 7, 3);
      job(0, 7, 0);
      bounce();
      job(0, 0, 2);
      job(0, 3, 0);
      job(0, 0, 0);
      job(0, TO, 1);
      for (int i = 0; i < 20; i++) begin
         job($urandom_range(0, 3), $urandom_range(0, TO), $urandom_range(0, 4));
      end
      job_reset($urandom_range(1, TO - 1));
      for (int i = 0; i < 260; i++) begin
         job(0, $urandom_range(1, 4), 0);
      end
      chk("run_count_sat", int'(run_count), 255);
      repeat (2) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
